// File: rtl/mem_arb_pkg.sv
// Shared state type and default geometry for the image-memory arbiter and its helpers.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NREQ_DEF      = 2;
    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 32;
    // One 352-pixel row is 88 four-pixel words.
    localparam int MAX_BURST_DEF = 88;
    localparam int ID_W          = $clog2(NREQ_DEF);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans upward from ptr+1, so the previous winner ranks lowest.
module rr_picker #(
    parameter  int NREQ  = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_o,
    output logic             any_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((int'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst lock sharing the single-port image memory between NREQ requesters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     busy_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_di_o,
    input  logic [DATA_W-1:0]        mem_do_i
);

    localparam int               IDX_W    = $clog2(NREQ);
    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BURST);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
    logic             rdFlag_q, rdFlag_d;
    logic [IDX_W-1:0] rdOwner_q;

    logic [NREQ-1:0]  pickWin;
    logic             pickAny;
    logic [IDX_W-1:0] pickIdx;
    logic             beat;
    logic             contend;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .win_o (pickWin),
        .any_o (pickAny)
    );

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pickWin[i]) pickIdx = IDX_W'(i);
        end
    end

    assign beat    = (state_q == BUSY) && req_i[owner_q];
    assign contend = |(req_i & ~gnt_q);

    assign mem_en_o   = beat;
    assign mem_we_o   = beat && we_i[owner_q];
    assign mem_addr_o = addr_i[int'(owner_q)*ADDR_W +: ADDR_W];
    assign mem_di_o   = wdata_i[int'(owner_q)*DATA_W +: DATA_W];

    // Release leaves the pointer on the old owner so it ranks lowest at the next arbitration.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        beatCnt_d = beatCnt_q;
        unique case (state_q)
            IDLE: begin
                if (pickAny) begin
                    state_d   = BUSY;
                    gnt_d     = pickWin;
                    owner_d   = pickIdx;
                    beatCnt_d = '0;
                end
            end
            BUSY: begin
                if (!beat || (beatCnt_q >= CNT_LAST && contend)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    ptr_d     = owner_q;
                    beatCnt_d = '0;
                end else if (beatCnt_q != CNT_SAT) begin
                    beatCnt_d = beatCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign rdFlag_d = beat && !we_i[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= IDX_W'(NREQ - 1);
            beatCnt_q <= '0;
            rdFlag_q  <= 1'b0;
            rdOwner_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            beatCnt_q <= beatCnt_d;
            rdFlag_q  <= rdFlag_d;
            rdOwner_q <= owner_q;
        end
    end

    // Read returns are steered by the piped owner id, not the live grant.
    always_comb begin
        rvalid_o = '0;
        if (rdFlag_q) rvalid_o[rdOwner_q] = 1'b1;
    end

    assign rdata_o = mem_do_i;
    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written burst sequences and a read-return scoreboard.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int MAXB = MAX_BURST_DEF;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  req, we;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, memDi, memDo;
    logic        busy, memEn, memWe;
    logic [15:0] memAddr;

    logic [31:0] tbMem [256];

    typedef struct {
        logic [ID_W-1:0] owner;
        logic [31:0]     data;
    } sb_t;
    sb_t sbQ[$];
    sb_t sbExp;

    typedef struct {
        logic [1:0]  req, we;
        logic [15:0] a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  eGnt;
        logic        eBusy, eEn, eWe;
        logic [15:0] eAddr;
        logic [31:0] eDi;
    } vec_t;
    vec_t vecs[$];

    int checks = 0;
    int errors = 0;
    int enCount;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rstN),
        .req_i      (req),
        .addr_i     ({addr1, addr0}),
        .we_i       (we),
        .wdata_i    ({wdata1, wdata0}),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .busy_o     (busy),
        .mem_en_o   (memEn),
        .mem_we_o   (memWe),
        .mem_addr_o (memAddr),
        .mem_di_o   (memDi),
        .mem_do_i   (memDo)
    );

    // Single-port memory with one cycle of read latency.
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) tbMem[memAddr[7:0]] <= memDi;
            else       memDo <= tbMem[memAddr[7:0]];
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every read return is matched in order against what the stimulus asked for.
    always @(negedge clk) begin
        if (rstN === 1'b1 && rvalid !== 2'b00) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rvalidUnexpected: got %b, expected 00", rvalid);
            end else begin
                sbExp = sbQ.pop_front();
                checkVal("rvalidVec", 32'(rvalid), 32'(2'b01 << sbExp.owner));
                checkVal("rdata", rdata, sbExp.data);
            end
        end
    end

    function automatic vec_t mkVec(input logic [1:0] r, w, input logic [15:0] a0, a1,
                                   input logic [31:0] d0, d1, input logic [1:0] g,
                                   input logic b, e, wr, input logic [15:0] ea, input logic [31:0] ed);
        vec_t v;
        v.req = r;   v.we = w;   v.a0 = a0;   v.a1 = a1;  v.d0 = d0;  v.d1 = d1;
        v.eGnt = g;  v.eBusy = b; v.eEn = e;  v.eWe = wr; v.eAddr = ea; v.eDi = ed;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] r, w, input logic [15:0] a0, a1,
                                 input logic [31:0] d0, d1);
        @(posedge clk);
        #1;
        req = r;  we = w;  addr0 = a0;  addr1 = a1;  wdata0 = d0;  wdata1 = d1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eGnt, input logic eBusy, eEn, eWe,
                               input logic [15:0] eAddr, input logic [31:0] eDi);
        @(negedge clk);
        checkVal({name, ".gnt"}, 32'(gnt), 32'(eGnt));
        checkVal({name, ".busy"}, 32'(busy), 32'(eBusy));
        checkVal({name, ".memEn"}, 32'(memEn), 32'(eEn));
        if (eEn) begin
            checkVal({name, ".memWe"}, 32'(memWe), 32'(eWe));
            checkVal({name, ".memAddr"}, 32'(memAddr), 32'(eAddr));
            if (eWe) checkVal({name, ".memDi"}, memDi, eDi);
        end
    endtask

    task automatic pushRead(input int owner, input logic [15:0] a);
        sb_t e;
        e.owner = ID_W'(owner);
        e.data  = tbMem[a[7:0]];
        sbQ.push_back(e);
    endtask

    task automatic runVec(input string name, input vec_t v);
        applyStimulus(v.req, v.we, v.a0, v.a1, v.d0, v.d1);
        if (v.eEn && !v.eWe) pushRead(v.eGnt[1] ? 1 : 0, v.eAddr);
        checkOutput(name, v.eGnt, v.eBusy, v.eEn, v.eWe, v.eAddr, v.eDi);
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        req = 2'b00;  we = 2'b00;  addr0 = 16'h0;  addr1 = 16'h0;  wdata0 = 32'h0;  wdata1 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        sbQ.delete();
    endtask

    task automatic releaseAndDrain(input string name, input logic [1:0] owner);
        runVec({name, ".rel"}, mkVec(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, owner, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0));
        runVec({name, ".idle"}, mkVec(2'b00, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        repeat (2) @(negedge clk);
        checkVal({name, ".sbEmpty"}, 32'(sbQ.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] a0, a1, ea;
        logic [1:0]  g;

        for (int i = 0; i < 256; i++) tbMem[i] = 32'hA500_0000 | 32'(i);
        tbMem[8'h10] = 32'hDEAD_BEEF;

        // req, we, a0, a1, d0, d1, gnt, busy, en, we, addr, di
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h0));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b10, 2'b10, 16'h0000, 16'h0000, 32'h0, 32'h1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b10, 2'b10, 16'h0000, 16'h0000, 32'h0, 32'h1, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0000, 32'h1));
        vecs.push_back(mkVec(2'b10, 2'b10, 16'h0000, 16'h0001, 32'h0, 32'h2, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0001, 32'h2));
        vecs.push_back(mkVec(2'b10, 2'b10, 16'h0000, 16'h0002, 32'h0, 32'h3, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0002, 32'h3));
        vecs.push_back(mkVec(2'b10, 2'b10, 16'h0000, 16'h0003, 32'h0, 32'h4, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0003, 32'h4));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b11, 2'b00, 16'h0020, 16'h0040, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b11, 2'b00, 16'h0020, 16'h0040, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h0));
        vecs.push_back(mkVec(2'b11, 2'b00, 16'h0021, 16'h0040, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0021, 32'h0));
        vecs.push_back(mkVec(2'b11, 2'b00, 16'h0022, 16'h0040, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h0022, 32'h0));
        vecs.push_back(mkVec(2'b10, 2'b00, 16'h0000, 16'h0040, 32'h0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b10, 2'b00, 16'h0000, 16'h0040, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b10, 2'b00, 16'h0000, 16'h0040, 32'h0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 16'h0040, 32'h0));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h0));
        vecs.push_back(mkVec(2'b00, 2'b00, 16'h0000, 16'h0000, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0));

        $display("[TB] vector table: single read, write burst, early release");
        resetDut();
        for (int i = 0; i < vecs.size(); i++) runVec($sformatf("vec%0d", i), vecs[i]);
        repeat (2) @(negedge clk);
        checkVal("vec.sbEmpty", 32'(sbQ.size()), 32'h0);

        $display("[TB] contention: alternating %0d-beat bursts", MAXB);
        resetDut();
        runVec("c3Arb", mkVec(2'b11, 2'b00, 16'h0, 16'h80, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < MAXB; i++) begin
                a0 = 16'(i);
                a1 = 16'h80 + 16'(i);
                ea = (b == 1) ? a1 : a0;
                g  = (b == 1) ? 2'b10 : 2'b01;
                runVec($sformatf("c3Own%0dBeat%0d", b, i),
                       mkVec(2'b11, 2'b00, a0, a1, 32'h0, 32'h0, g, 1'b1, 1'b1, 1'b0, ea, 32'h0));
            end
            runVec($sformatf("c3Gap%0d", b),
                   mkVec(2'b11, 2'b00, 16'h0, 16'h80, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        end
        runVec("c3Again", mkVec(2'b11, 2'b00, 16'h5, 16'h80, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h5, 32'h0));
        releaseAndDrain("c3", 2'b01);

        $display("[TB] no contention: 200-beat read burst");
        resetDut();
        runVec("c4Arb", mkVec(2'b01, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        enCount = 0;
        for (int i = 0; i < 200; i++) begin
            a0 = 16'(i);
            runVec($sformatf("c4Beat%0d", i),
                   mkVec(2'b01, 2'b00, a0, 16'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, a0, 32'h0));
            if (memEn) enCount++;
        end
        checkVal("c4EnCount", 32'(enCount), 32'd200);
        releaseAndDrain("c4", 2'b01);

        $display("[TB] asynchronous reset in mid-burst");
        resetDut();
        runVec("r1Arb", mkVec(2'b01, 2'b00, 16'h5, 16'h0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        runVec("r1Beat", mkVec(2'b01, 2'b00, 16'h5, 16'h0, 32'h0, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 16'h5, 32'h0));
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkVal("r1.gnt", 32'(gnt), 32'h0);
        checkVal("r1.rvalid", 32'(rvalid), 32'h0);
        checkVal("r1.memEn", 32'(memEn), 32'h0);
        checkVal("r1.busy", 32'(busy), 32'h0);
        sbQ.delete();
        req = 2'b00;
        @(negedge clk);
        rstN = 1'b1;
        runVec("r1Arb1", mkVec(2'b10, 2'b00, 16'h0, 16'h7, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0));
        runVec("r1Gnt1", mkVec(2'b10, 2'b00, 16'h0, 16'h7, 32'h0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 16'h7, 32'h0));
        releaseAndDrain("r1", 2'b10);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
